decode_queue: RTL and testbench

- Consumer end of the instruction-fetch handshake: accepts one instruction per fetch handshake into a small FIFO.
- Drives the fetch control inputs:
  - stall, for back-pressure.
  - nextpc, for sequential / JAL-predicted / redirected PC.
  - kill, for flush.
- Presents decoded RV32I fields to the issue stage over a valid/ready interface.
- Sits between the fetch unit and issue/execute; redirects arrive from execute.

---
 rtl/decode_queue_pkg.sv | 24 ++
 rtl/decode_queue_inst_fields.sv | 44 ++++
 rtl/decode_queue.sv | 162 ++++++++++++++++
 tb/tb_decode_queue.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_queue_pkg.sv
// Shared definitions for the decode queue: RV32I opcode constants and the
// decoded-instruction record presented to the issue stage.
package decode_queue_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [6:0]  opcode;
  } dec_inst_t;

endpackage

// File: rtl/decode_queue_inst_fields.sv
// Combinational RV32I field extraction.
// Ports:
//   inst   - raw 32-bit instruction word
//   rd/rs1/rs2 - register fields taken straight from their bit positions
//   imm    - sign-extended immediate for I/S/B/U/J formats, 0 otherwise
//   opcode - inst[6:0]
module inst_fields
  import decode_queue_pkg::*;
(
  input  logic [31:0] inst,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic [6:0]  opcode
);

  logic signed [31:0] imm_s;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign imm    = imm_s;

  always_comb begin
    imm_s = '0;
    case (inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR:
        imm_s = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:
        imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        imm_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm_s = {inst[31:12], 12'h000};
      OP_JAL:
        imm_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm_s = '0;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Decode queue: consumer end of the fetch handshake. Buffers fetched
// instructions in a DEPTH-entry FIFO, steers fetch via stall/kill/nextpc
// (sequential, JAL-predicted, or redirected PC) and presents the decoded head
// entry to issue over a valid/ready interface.
// Ports:
//   clk, reset (async, active-low)
//   instruction0, inst0_pc, fetch_ready      - fetch side input
//   stall, kill, nextpc                      - fetch control
//   redirect_valid, redirect_pc              - redirect from execute
//   dec_valid, dec_ready, dec_pc, dec_inst,
//   dec_rd, dec_rs1, dec_rs2, dec_imm,
//   dec_opcode                               - issue side
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction0,
  input  logic [31:0] inst0_pc,
  input  logic        fetch_ready,
  output logic        stall,
  output logic        kill,
  output logic [31:0] nextpc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_inst,
  output logic [4:0]  dec_rd,
  output logic [4:0]  dec_rs1,
  output logic [4:0]  dec_rs2,
  output logic [31:0] dec_imm,
  output logic [6:0]  dec_opcode
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  // RESET_PC only records where fetch starts; it has no effect on logic.
  localparam logic [31:0] unused_reset_pc = RESET_PC;

  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_inst [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          pend;
  logic [31:0]   pend_pc;

  logic fhs, push, pop;

  // Stall only from registered state; while a redirect is pending the
  // handshake must happen so fetch can load pend_pc.
  assign stall     = (count == FULL_CNT) & ~pend;
  assign fhs       = fetch_ready & ~stall;
  assign push      = fhs & ~redirect_valid & ~pend;
  assign dec_valid = (count != '0);
  assign pop       = dec_valid & dec_ready;
  assign kill      = redirect_valid | pend;

  // Control state: pointers, occupancy, pending redirect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pend   <= 1'b0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pend   <= ~fhs;
    end else begin
      if (pend && fhs) pend <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage, not reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= inst0_pc;
      mem_inst[wr_ptr] <= instruction0;
    end
    if (redirect_valid) pend_pc <= redirect_pc;
  end

  // JAL target prediction on the incoming word
  logic [4:0]         jal_rd, jal_rs1, jal_rs2;
  logic [6:0]         jal_op;
  logic [31:0]        jal_imm_raw;
  logic signed [31:0] jal_imm;
  logic               unused_jal_fields;

  inst_fields u_jal_fields (
    .inst   (instruction0),
    .rd     (jal_rd),
    .rs1    (jal_rs1),
    .rs2    (jal_rs2),
    .imm    (jal_imm_raw),
    .opcode (jal_op)
  );

  assign jal_imm           = signed'(jal_imm_raw);
  assign unused_jal_fields = ^{jal_rd, jal_rs1, jal_rs2};

  always_comb begin
    if (redirect_valid)   nextpc = redirect_pc;
    else if (pend)        nextpc = pend_pc;
    else if (jal_op == OP_JAL) nextpc = inst0_pc + $unsigned(jal_imm);
    else                  nextpc = inst0_pc + 32'd4;
  end

  // Head entry decode; all fields read as zero while the queue is empty
  logic [31:0] head_inst;
  logic [4:0]  h_rd, h_rs1, h_rs2;
  logic [31:0] h_imm;
  logic [6:0]  h_op;
  dec_inst_t   head;

  assign head_inst = mem_inst[rd_ptr];

  inst_fields u_head_fields (
    .inst   (head_inst),
    .rd     (h_rd),
    .rs1    (h_rs1),
    .rs2    (h_rs2),
    .imm    (h_imm),
    .opcode (h_op)
  );

  always_comb begin
    head = '0;
    if (dec_valid) begin
      head.pc     = mem_pc[rd_ptr];
      head.inst   = head_inst;
      head.rd     = h_rd;
      head.rs1    = h_rs1;
      head.rs2    = h_rs2;
      head.imm    = h_imm;
      head.opcode = h_op;
    end
  end

  assign dec_pc     = head.pc;
  assign dec_inst   = head.inst;
  assign dec_rd     = head.rd;
  assign dec_rs1    = head.rs1;
  assign dec_rs2    = head.rs2;
  assign dec_imm    = head.imm;
  assign dec_opcode = head.opcode;

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] ADDI = 32'h00100093;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction0, inst0_pc, redirect_pc;
  logic        fetch_ready, redirect_valid, dec_ready;
  logic        stall, kill, dec_valid;
  logic [31:0] nextpc, dec_pc, dec_inst, dec_imm;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [6:0]  dec_opcode;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of {pc, inst}, pending redirect flag and target
  logic [63:0] m_q [$];
  bit          m_pend;
  logic [31:0] m_pend_pc;

  decode_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .instruction0(instruction0), .inst0_pc(inst0_pc), .fetch_ready(fetch_ready),
    .stall(stall), .kill(kill), .nextpc(nextpc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_inst(dec_inst),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_imm(dec_imm), .dec_opcode(dec_opcode)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Immediate value from the ISA bit layout, computed arithmetically
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int v;
    case (w[6:0])
      7'h03, 7'h13, 7'h67: v = int'(w[31:20]) - (w[31] ? 4096 : 0);
      7'h23: v = int'({w[31:25], w[11:7]}) - (w[31] ? 4096 : 0);
      7'h63: v = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048
                 - int'(w[31]) * 4096;
      7'h37, 7'h17: v = int'(w & 32'hFFFFF000);
      7'h6F: v = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
                 - int'(w[31]) * (1 << 20);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic exp_stall();
    return (m_q.size() == DEPTH) && !m_pend;
  endfunction

  function automatic logic exp_kill();
    return redirect_valid || m_pend;
  endfunction

  function automatic logic [31:0] exp_nextpc();
    if (redirect_valid) return redirect_pc;
    if (m_pend) return m_pend_pc;
    if (instruction0[6:0] == 7'h6F) return inst0_pc + ref_imm(instruction0);
    return inst0_pc + 32'd4;
  endfunction

  function automatic logic [63:0] exp_head();
    if (m_q.size() == 0) return 64'h0;
    return m_q[0];
  endfunction

  task automatic model_step();
    bit hs, pop_v, push_v;
    hs     = fetch_ready && !exp_stall();
    pop_v  = (m_q.size() != 0) && dec_ready;
    push_v = hs && !redirect_valid && !m_pend;
    if (redirect_valid) begin
      m_q.delete();
      m_pend    = !hs;
      m_pend_pc = redirect_pc;
    end else begin
      if (pop_v) void'(m_q.pop_front());
      if (push_v) m_q.push_back({inst0_pc, instruction0});
      if (m_pend && hs) m_pend = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
  endtask

  task automatic set_in(input logic fr, input logic [31:0] inst, input logic [31:0] pc,
                        input logic rv, input logic [31:0] rpc, input logic dr);
    fetch_ready    = fr;
    instruction0   = inst;
    inst0_pc       = pc;
    redirect_valid = rv;
    redirect_pc    = rpc;
    dec_ready      = dr;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m_q.delete();
    m_pend = 1'b0;
    set_in(0, 32'h0, 32'h0, 0, 32'h0, 0);
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid: got %b want 0", dec_valid); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_checks++; if (kill !== 1'b0) begin n_fail++; $display("FAIL reset_kill: got %b want 0", kill); end
    n_checks++; if (dec_pc !== 32'h0 || dec_imm !== 32'h0 || dec_rd !== 5'h0)
      begin n_fail++; $display("FAIL reset_fields: got pc %h imm %h rd %0d want zeros", dec_pc, dec_imm, dec_rd); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] words [3];
    words[0] = 32'h00100093; words[1] = 32'hFFB00093; words[2] = 32'h7FF00113;
    for (int i = 0; i < 3; i++) begin
      set_in(1, words[i], 32'(4 * i), 0, 32'h0, 1);
      n_checks++; if (nextpc !== 32'(4 * i + 4))
        begin n_fail++; $display("FAIL seq_nextpc: got %h want %h", nextpc, 32'(4 * i + 4)); end
      if (i == 0) begin
        n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL seq_empty: got %b want 0", dec_valid); end
      end else begin
        n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'(4 * (i - 1)))
          begin n_fail++; $display("FAIL seq_head: got v%b pc %h want pc %h", dec_valid, dec_pc, 32'(4 * (i - 1))); end
        n_checks++; if (dec_imm !== ref_imm(words[i - 1]))
          begin n_fail++; $display("FAIL seq_imm: got %h want %h", dec_imm, ref_imm(words[i - 1])); end
      end
      tick();
    end
    set_in(0, 32'h0, 32'h0, 0, 32'h0, 1);
    n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h8)
      begin n_fail++; $display("FAIL seq_last: got v%b pc %h want pc 8", dec_valid, dec_pc); end
    n_checks++; if (dec_imm !== 32'h7FF || dec_rd !== 5'd2)
      begin n_fail++; $display("FAIL seq_last_fields: got imm %h rd %0d want 7ff rd 2", dec_imm, dec_rd); end
    tick();
    // sequential PC wraps at the top of the address space
    set_in(1, ADDI, 32'hFFFFFFFC, 0, 32'h0, 1);
    n_checks++; if (nextpc !== 32'h0) begin n_fail++; $display("FAIL seq_wrap: got %h want 0", nextpc); end
    tick();
    set_in(0, 32'h0, 32'h0, 0, 32'h0, 1);
    n_checks++; if (dec_pc !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL seq_wrap_head: got %h want fffffffc", dec_pc); end
    tick();
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL seq_drained: got %b want 0", dec_valid); end
  endtask

  task automatic test_jal();
    set_in(1, 32'h0100006F, 32'h20, 0, 32'h0, 0);
    n_checks++; if (nextpc !== 32'h30) begin n_fail++; $display("FAIL jal_nextpc: got %h want 30", nextpc); end
    tick();
    set_in(0, 32'h0, 32'h0, 0, 32'h0, 0);
    n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h20)
      begin n_fail++; $display("FAIL jal_head: got v%b pc %h want pc 20", dec_valid, dec_pc); end
    n_checks++; if (dec_imm !== 32'd16 || dec_rd !== 5'd0 || dec_opcode !== 7'h6F)
      begin n_fail++; $display("FAIL jal_fields: got imm %h rd %0d op %h want 10/0/6f", dec_imm, dec_rd, dec_opcode); end
    // backward JAL (jal x1,-8) with negative immediate
    set_in(0, 32'hFF9FF0EF, 32'h100, 0, 32'h0, 1);
    n_checks++; if (nextpc !== 32'hF8) begin n_fail++; $display("FAIL jal_back: got %h want f8", nextpc); end
    tick();
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL jal_drained: got %b want 0", dec_valid); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      set_in(1, ADDI, 32'(32'h40 + 4 * i), 0, 32'h0, 0);
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL full_fill_stall: got %b want 0", stall); end
      tick();
    end
    set_in(1, ADDI, 32'h50, 0, 32'h0, 0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL full_stall: got %b want 1", stall); end
    tick(); tick();
    n_checks++; if (stall !== 1'b1 || dec_pc !== 32'h40)
      begin n_fail++; $display("FAIL full_held: got stall %b pc %h want 1/40", stall, dec_pc); end
    set_in(1, ADDI, 32'h50, 0, 32'h0, 1);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL full_no_comb_path: got %b want 1", stall); end
    tick();
    set_in(1, ADDI, 32'h50, 0, 32'h0, 0);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL full_release: got %b want 0", stall); end
    tick();
    set_in(0, 32'h0, 32'h0, 0, 32'h0, 0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL full_refill: got %b want 1", stall); end
    for (int i = 0; i < 4; i++) begin
      set_in(0, 32'h0, 32'h0, 0, 32'h0, 1);
      n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'(32'h44 + 4 * i))
        begin n_fail++; $display("FAIL full_order: got v%b pc %h want %h", dec_valid, dec_pc, 32'(32'h44 + 4 * i)); end
      tick();
    end
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b want 0", dec_valid); end
  endtask

  task automatic test_redirect_nohs();
    for (int i = 0; i < 3; i++) begin
      set_in(1, ADDI, 32'(4 * i), 0, 32'h0, 0);
      tick();
    end
    set_in(0, 32'h0, 32'h0, 1, 32'h100, 0);
    n_checks++; if (kill !== 1'b1 || nextpc !== 32'h100)
      begin n_fail++; $display("FAIL rdr_now: got kill %b nextpc %h want 1/100", kill, nextpc); end
    tick();
    set_in(0, 32'h0, 32'h0, 0, 32'h0, 0);
    n_checks++; if (dec_valid !== 1'b0 || kill !== 1'b1 || nextpc !== 32'h100)
      begin n_fail++; $display("FAIL rdr_pend: got v%b kill %b nextpc %h want 0/1/100", dec_valid, kill, nextpc); end
    tick();
    set_in(1, ADDI, 32'h0C, 0, 32'h0, 0);
    n_checks++; if (stall !== 1'b0 || kill !== 1'b1 || nextpc !== 32'h100)
      begin n_fail++; $display("FAIL rdr_stale: got stall %b kill %b nextpc %h want 0/1/100", stall, kill, nextpc); end
    tick();
    set_in(0, 32'h0, 32'h0, 0, 32'h0, 0);
    n_checks++; if (kill !== 1'b0 || dec_valid !== 1'b0)
      begin n_fail++; $display("FAIL rdr_discard: got kill %b v%b want 0/0", kill, dec_valid); end
    set_in(1, ADDI, 32'h100, 0, 32'h0, 0);
    n_checks++; if (nextpc !== 32'h104) begin n_fail++; $display("FAIL rdr_resume: got %h want 104", nextpc); end
    tick();
    set_in(0, 32'h0, 32'h0, 0, 32'h0, 1);
    n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100)
      begin n_fail++; $display("FAIL rdr_first: got v%b pc %h want 100", dec_valid, dec_pc); end
    tick();
  endtask

  task automatic test_redirect_hs();
    set_in(1, ADDI, 32'h180, 0, 32'h0, 0);
    tick();
    set_in(1, ADDI, 32'h200, 1, 32'h300, 1);
    n_checks++; if (nextpc !== 32'h300 || kill !== 1'b1)
      begin n_fail++; $display("FAIL rhs_now: got nextpc %h kill %b want 300/1", nextpc, kill); end
    tick();
    set_in(0, 32'h0, 32'h0, 0, 32'h0, 0);
    n_checks++; if (kill !== 1'b0 || dec_valid !== 1'b0)
      begin n_fail++; $display("FAIL rhs_after: got kill %b v%b want 0/0", kill, dec_valid); end
    set_in(1, ADDI, 32'h300, 0, 32'h0, 0);
    n_checks++; if (nextpc !== 32'h304) begin n_fail++; $display("FAIL rhs_resume: got %h want 304", nextpc); end
    tick();
    set_in(0, 32'h0, 32'h0, 0, 32'h0, 1);
    n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h300)
      begin n_fail++; $display("FAIL rhs_head: got v%b pc %h want 300", dec_valid, dec_pc); end
    tick();
  endtask

  task automatic test_async_reset();
    set_in(1, ADDI, 32'h400, 0, 32'h0, 0); tick();
    set_in(1, ADDI, 32'h404, 0, 32'h0, 0); tick();
    set_in(0, 32'h0, 32'h0, 0, 32'h0, 0);
    n_checks++; if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got %b want 1", dec_valid); end
    #1 reset = 1'b0;
    #1;
    n_checks++; if (dec_valid !== 1'b0 || stall !== 1'b0 || kill !== 1'b0 || dec_pc !== 32'h0)
      begin n_fail++; $display("FAIL arst_clear: got v%b stall %b kill %b pc %h want 0/0/0/0", dec_valid, stall, kill, dec_pc); end
    m_q.delete();
    m_pend = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    set_in(1, ADDI, 32'h500, 0, 32'h0, 0); tick();
    set_in(0, 32'h0, 32'h0, 0, 32'h0, 1);
    n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h500)
      begin n_fail++; $display("FAIL arst_resume: got v%b pc %h want 500", dec_valid, dec_pc); end
    tick();
  endtask

  task automatic test_random();
    logic [6:0]  ops [9];
    logic [31:0] r, exp_pc_w, exp_inst_w;
    logic [63:0] h;
    ops[0] = 7'h03; ops[1] = 7'h13; ops[2] = 7'h67; ops[3] = 7'h23; ops[4] = 7'h63;
    ops[5] = 7'h37; ops[6] = 7'h17; ops[7] = 7'h6F; ops[8] = 7'h33;
    for (int c = 0; c < 2000; c++) begin
      r = $urandom();
      set_in(($urandom_range(99) < 70), {r[31:7], ops[$urandom_range(8)]},
             $urandom() & 32'hFFFFFFFC, ($urandom_range(99) < 8),
             $urandom() & 32'hFFFFFFFC, ($urandom_range(99) < 60));
      h = exp_head();
      exp_pc_w   = h[63:32];
      exp_inst_w = h[31:0];
      n_checks++; if (stall !== exp_stall()) begin n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", c, stall, exp_stall()); end
      n_checks++; if (kill !== exp_kill()) begin n_fail++; $display("FAIL rnd_kill c%0d: got %b want %b", c, kill, exp_kill()); end
      n_checks++; if (nextpc !== exp_nextpc()) begin n_fail++; $display("FAIL rnd_nextpc c%0d: got %h want %h", c, nextpc, exp_nextpc()); end
      n_checks++; if (dec_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, dec_valid, (m_q.size() != 0)); end
      n_checks++; if (dec_pc !== exp_pc_w || dec_inst !== exp_inst_w)
        begin n_fail++; $display("FAIL rnd_head c%0d: got %h/%h want %h/%h", c, dec_pc, dec_inst, exp_pc_w, exp_inst_w); end
      n_checks++; if (dec_imm !== ref_imm(exp_inst_w) || dec_opcode !== exp_inst_w[6:0])
        begin n_fail++; $display("FAIL rnd_imm c%0d: got %h op %h want %h op %h", c, dec_imm, dec_opcode, ref_imm(exp_inst_w), exp_inst_w[6:0]); end
      n_checks++; if (dec_rd !== exp_inst_w[11:7] || dec_rs1 !== exp_inst_w[19:15] || dec_rs2 !== exp_inst_w[24:20])
        begin n_fail++; $display("FAIL rnd_regs c%0d: got %0d %0d %0d want %0d %0d %0d", c, dec_rd, dec_rs1, dec_rs2,
                                 exp_inst_w[11:7], exp_inst_w[19:15], exp_inst_w[24:20]); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jal();
    test_full();
    test_redirect_nohs();
    test_redirect_hs();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
